// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry
// skid buffer (registered in_ready), synchronous flush and occupancy output.
module pipe_stage_skid #(
    parameter int DATA_W         = 110,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    // With a skid buffer in_ready depends only on state flops; without one it
    // looks through to out_ready so a stalled single register blocks upstream.
    assign in_ready  = (SKID != 0) ? (state_q != ST_FULL)
                                   : ((state_q == ST_EMPTY) || out_ready);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = {state_q == ST_FULL, state_q == ST_ONE};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    // Without a skid buffer an input fire in ONE implies an output fire.
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: SKID=1 and SKID=0 instances compared every cycle against
// a FIFO-occupancy model, plus directed vectors with literal expectations.
module tb_pipe_stage_skid;

    localparam int W = 110;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   fl, iv, ordy;
    logic [W-1:0] idt [2];
    logic [1:0]   irdy, ov;
    logic [W-1:0] od [2];
    logic [1:0]   occ [2];

    int passed = 0;
    int total  = 0;

    // Model: per instance, an ordered list of held beats and the last head value.
    logic [W-1:0] mem  [2][2];
    int unsigned  cnt  [2];
    logic [W-1:0] last [2];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(W), .SKID(0), .CLEAR_ON_FLUSH(1)) u_dut0 (
        .clk(clk), .rst(rst), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(idt[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .occupancy(occ[0])
    );

    pipe_stage_skid #(.DATA_W(W), .SKID(1), .CLEAR_ON_FLUSH(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(idt[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .occupancy(occ[1])
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic model_ready(input int i);
        if (i == 1) return (cnt[i] < 2);
        return (cnt[i] == 0) || (ordy[i] == 1'b1);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cnt[i]  = 0;
                last[i] = '0;
            end else begin
                logic inf, outf;
                inf  = iv[i] && model_ready(i);
                outf = (cnt[i] > 0) && ordy[i];
                if (fl[i]) begin
                    cnt[i]  = 0;
                    last[i] = '0;
                end else begin
                    if (outf) begin
                        mem[i][0] = mem[i][1];
                        cnt[i]    = cnt[i] - 1;
                    end
                    if (inf) begin
                        mem[i][cnt[i]] = idt[i];
                        cnt[i]         = cnt[i] + 1;
                    end
                    if (cnt[i] > 0) last[i] = mem[i][0];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d.out_valid", i), 128'(ov[i]), 128'(cnt[i] > 0));
                chk($sformatf("m%0d.out_data", i), 128'(od[i]),
                    128'((cnt[i] > 0) ? mem[i][0] : last[i]));
                chk($sformatf("m%0d.occupancy", i), 128'(occ[i]), 128'(cnt[i]));
                chk($sformatf("m%0d.in_ready", i), 128'(irdy[i]), 128'(model_ready(i)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [W-1:0] d,
                         input logic r, input logic f);
        iv[i]   = v;
        idt[i]  = d;
        ordy[i] = r;
        fl[i]   = f;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r;
        logic [W-1:0] z;
        z = '0;
        drive(0, 1'b0, z, 1'b1, 1'b0);
        drive(1, 1'b0, z, 1'b1, 1'b0);
        #12;
        chk("rst.out_valid", 128'(ov[1]), 128'(0));
        chk("rst.occupancy", 128'(occ[1]), 128'(0));
        chk("rst.in_ready", 128'(irdy[1]), 128'(1));
        chk("rst.out_data", 128'(od[1]), 128'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        tick();

        // Streaming 1..4, full throughput
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1'b1, W'(k), 1'b1, 1'b0);
            tick();
            chk("stream.data", 128'(od[1]), 128'(k));
            chk("stream.occ", 128'(occ[1]), 128'(1));
            chk("stream.rdy", 128'(irdy[1]), 128'(1));
        end
        drive(1, 1'b0, z, 1'b1, 1'b0);
        tick();
        chk("stream.drain", 128'(occ[1]), 128'(0));

        // Backpressure A,B,C
        drive(1, 1'b1, W'(10), 1'b0, 1'b0); tick();
        chk("bp.a_main", 128'(od[1]), 128'('hA));
        drive(1, 1'b1, W'(11), 1'b0, 1'b0); tick();
        chk("bp.full_occ", 128'(occ[1]), 128'(2));
        chk("bp.full_rdy", 128'(irdy[1]), 128'(0));
        drive(1, 1'b1, W'(12), 1'b0, 1'b0); tick();
        chk("bp.hold", 128'(od[1]), 128'('hA));
        drive(1, 1'b1, W'(12), 1'b1, 1'b0); tick();
        chk("bp.b_out", 128'(od[1]), 128'('hB));
        chk("bp.b_occ", 128'(occ[1]), 128'(1));
        tick();
        chk("bp.c_out", 128'(od[1]), 128'('hC));
        drive(1, 1'b0, z, 1'b1, 1'b0); tick();
        chk("bp.empty", 128'(ov[1]), 128'(0));

        // Flush while FULL with an offered beat 0xD
        drive(1, 1'b1, W'('h11), 1'b0, 1'b0); tick();
        drive(1, 1'b1, W'('h22), 1'b0, 1'b0); tick();
        chk("fl.full", 128'(occ[1]), 128'(2));
        drive(1, 1'b1, W'('hD), 1'b0, 1'b1); tick();
        chk("fl.valid", 128'(ov[1]), 128'(0));
        chk("fl.occ", 128'(occ[1]), 128'(0));
        chk("fl.rdy", 128'(irdy[1]), 128'(1));
        chk("fl.data", 128'(od[1]), 128'(0));
        drive(1, 1'b0, z, 1'b1, 1'b0); tick();
        chk("fl.no_d", 128'(ov[1]), 128'(0));

        // Async reset mid-stall
        drive(1, 1'b1, W'('h33), 1'b0, 1'b0); tick();
        drive(1, 1'b1, W'('h44), 1'b0, 1'b0); tick();
        drive(1, 1'b0, z, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", 128'(ov[1]), 128'(0));
        chk("arst.occ", 128'(occ[1]), 128'(0));
        chk("arst.rdy", 128'(irdy[1]), 128'(1));
        chk("arst.data", 128'(od[1]), 128'(0));
        #1 rst = 1'b0;
        drive(1, 1'b0, z, 1'b1, 1'b0);
        tick();

        // SKID=0 stall equivalence
        drive(0, 1'b1, W'('h55), 1'b1, 1'b0); tick();
        chk("s0.load", 128'(od[0]), 128'('h55));
        drive(0, 1'b1, W'('h66), 1'b0, 1'b0); #1;
        chk("s0.stall_rdy", 128'(irdy[0]), 128'(0));
        tick();
        chk("s0.hold", 128'(od[0]), 128'('h55));
        chk("s0.occ", 128'(occ[0]), 128'(1));
        drive(0, 1'b1, W'('h66), 1'b1, 1'b0); #1;
        chk("s0.go_rdy", 128'(irdy[0]), 128'(1));
        tick();
        chk("s0.next", 128'(od[0]), 128'('h66));
        drive(0, 1'b0, z, 1'b1, 1'b0); tick();
        chk("s0.empty", 128'(ov[0]), 128'(0));

        // Random traffic on both instances
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                r = {$urandom(), $urandom(), $urandom(), $urandom()};
                drive(i, 1'($urandom_range(0, 99) < 65), r[W-1:0],
                      1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 3));
            end
            tick();
        end
        drive(0, 1'b0, z, 1'b1, 1'b0);
        drive(1, 1'b0, z, 1'b1, 1'b0);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
